// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - LED sweep / ping-pong pattern engine with step prescaler
module led_pattern_engine #(
  parameter  int N_LED = 16,
  parameter  int PRE_W = 4,
  localparam int PW    = $clog2(N_LED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             idle,
  input  logic [1:0]       mode,
  input  logic [PRE_W-1:0] step_div,
  output logic [N_LED-1:0] led,
  output logic [PW-1:0]    pos,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0]    MODE_NONE = 2'b00;
  localparam logic [1:0]    MODE_DOWN = 2'b10;
  localparam logic [1:0]    MODE_PING = 2'b11;
  localparam logic [PW-1:0] POS_LAST  = PW'(N_LED - 1);
  localparam logic [PW-1:0] POS_PEN   = PW'(N_LED - 2);

  state_t           state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    pos_d;
  logic [N_LED-1:0] led_d;
  logic             busy_d, done_d;

  logic [PW-1:0]    adv_pos;
  logic             adv_up;
  logic             adv_wrap;

  // pos is always kept below N_LED, so the index never leaves the vector
  function automatic logic [N_LED-1:0] onehot(input logic [PW-1:0] p);
    logic [N_LED-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Next position for one pattern step, including wrap/reversal detection
  always_comb begin
    adv_pos  = pos;
    adv_up   = dir_up_q;
    adv_wrap = 1'b0;
    case (mode_q)
      MODE_DOWN: begin
        if (pos == '0) begin
          adv_pos  = POS_LAST;
          adv_wrap = 1'b1;
        end else begin
          adv_pos = pos - 1'b1;
        end
      end
      MODE_PING: begin
        if (dir_up_q) begin
          if (pos == POS_LAST) begin
            adv_pos  = POS_PEN;
            adv_up   = 1'b0;
            adv_wrap = 1'b1;
          end else begin
            adv_pos = pos + 1'b1;
          end
        end else begin
          if (pos == '0) begin
            adv_pos  = PW'(1);
            adv_up   = 1'b1;
            adv_wrap = 1'b1;
          end else begin
            adv_pos = pos - 1'b1;
          end
        end
      end
      default: begin
        if (pos == POS_LAST) begin
          adv_pos  = '0;
          adv_wrap = 1'b1;
        end else begin
          adv_pos = pos + 1'b1;
        end
      end
    endcase
  end

  // FSM next state and next values of every output register
  always_comb begin
    state_d  = state_q;
    pos_d    = pos;
    dir_up_d = dir_up_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    led_d    = led;
    busy_d   = busy;
    done_d   = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          pos_d    = '0;
          dir_up_d = 1'b1;
          presc_d  = '0;
          led_d    = '0;
          busy_d   = 1'b0;
          if (start && (mode != MODE_NONE)) begin
            state_d = S_RUN;
            mode_d  = mode;
            pos_d   = (mode == MODE_DOWN) ? POS_LAST : '0;
            led_d   = onehot(pos_d);
            busy_d  = 1'b1;
          end
        end
        S_RUN: begin
          if (!start) begin
            state_d  = S_IDLE;
            pos_d    = '0;
            dir_up_d = 1'b1;
            presc_d  = '0;
            led_d    = '0;
            busy_d   = 1'b0;
          end else if (idle) begin
            state_d = S_PAUSE;
            led_d   = '0;
          end else if (presc_q >= step_div) begin
            // >= so a lowered step_div takes effect on the very next cycle
            presc_d  = '0;
            pos_d    = adv_pos;
            dir_up_d = adv_up;
            done_d   = adv_wrap;
            led_d    = onehot(adv_pos);
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (!start) begin
            state_d  = S_IDLE;
            pos_d    = '0;
            dir_up_d = 1'b1;
            presc_d  = '0;
            led_d    = '0;
            busy_d   = 1'b0;
          end else if (!idle) begin
            state_d = S_RUN;
            presc_d = '0;
            led_d   = onehot(pos);
          end
        end
        default: begin
          state_d  = S_IDLE;
          pos_d    = '0;
          dir_up_d = 1'b1;
          presc_d  = '0;
          led_d    = '0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pos      <= '0;
      dir_up_q <= 1'b1;
      presc_q  <= '0;
      mode_q   <= MODE_NONE;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos      <= pos_d;
      dir_up_q <= dir_up_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      led      <= led_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed self-checking bench for led_pattern_engine
module tb_led_pattern_engine;

  logic        clk = 1'b0;
  logic        reset, en, start, idle;
  logic [1:0]  mode;
  logic [3:0]  step_div;
  logic [15:0] led;
  logic [3:0]  pos;
  logic        busy, done;
  logic [9:0]  led10;
  logic [3:0]  pos10;
  logic        busy10, done10;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp;
  logic [9:0]  exp10;

  led_pattern_engine #(.N_LED(16), .PRE_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .idle(idle),
    .mode(mode), .step_div(step_div),
    .led(led), .pos(pos), .busy(busy), .done(done)
  );

  led_pattern_engine #(.N_LED(10), .PRE_W(4)) dut10 (
    .clk(clk), .reset(reset), .en(en), .start(start), .idle(idle),
    .mode(mode), .step_div(step_div),
    .led(led10), .pos(pos10), .busy(busy10), .done(done10)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; start = 1'b1; idle = 1'b0; mode = 2'b01; step_div = 4'd0;
    step();
    n_cmp++;
    if ({led, pos, busy, done} !== {16'h0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset16: led=%h pos=%0d busy=%b done=%b want led=0000 pos=0 busy=0 done=0", led, pos, busy, done);
    end
    n_cmp++;
    if ({led10, pos10, busy10, done10} !== {10'h0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset10: led=%h pos=%0d busy=%b done=%b want all zero", led10, pos10, busy10, done10);
    end
    start = 1'b0; reset = 1'b0;
    step();
  endtask

  task automatic test_mode_none();
    mode = 2'b00; start = 1'b1;
    step(); step();
    n_cmp++;
    if ({led, busy} !== {16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL mode_none: led=%h busy=%b want led=0000 busy=0", led, busy);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_sweep_up();
    mode = 2'b01; step_div = 4'd0; start = 1'b1;
    step();
    n_cmp++;
    if ({led, busy, done} !== {16'h0001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL up_first: led=%h busy=%b done=%b want led=0001 busy=1 done=0", led, busy, done);
    end
    for (int i = 1; i < 16; i++) begin
      step();
      exp = 16'h0001 << i;
      n_cmp++;
      if ({led, busy, done} !== {exp, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL up_step%0d: led=%h busy=%b done=%b want led=%h busy=1 done=0", i, led, busy, done, exp);
      end
    end
    step();
    n_cmp++;
    if ({led, busy, done} !== {16'h0001, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL up_wrap: led=%h busy=%b done=%b want led=0001 busy=1 done=1", led, busy, done);
    end
    step();
    n_cmp++;
    if ({led, done} !== {16'h0002, 1'b0}) begin
      n_fail++;
      $display("FAIL up_after_wrap: led=%h done=%b want led=0002 done=0", led, done);
    end
    start = 1'b0;
    step();
    n_cmp++;
    if ({led, pos, busy} !== {16'h0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL up_stop: led=%h pos=%0d busy=%b want led=0000 pos=0 busy=0", led, pos, busy);
    end
  endtask

  task automatic test_sweep_down();
    mode = 2'b10; step_div = 4'd0; start = 1'b1;
    step();
    n_cmp++;
    if ({led, pos, done} !== {16'h8000, 4'd15, 1'b0}) begin
      n_fail++;
      $display("FAIL down_first: led=%h pos=%0d done=%b want led=8000 pos=15 done=0", led, pos, done);
    end
    for (int i = 14; i >= 0; i--) begin
      step();
      exp = 16'h0001 << i;
      n_cmp++;
      if ({led, done} !== {exp, 1'b0}) begin
        n_fail++;
        $display("FAIL down_step%0d: led=%h done=%b want led=%h done=0", i, led, done, exp);
      end
    end
    step();
    n_cmp++;
    if ({led, done} !== {16'h8000, 1'b1}) begin
      n_fail++;
      $display("FAIL down_wrap: led=%h done=%b want led=8000 done=1", led, done);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_ping_pong();
    mode = 2'b11; step_div = 4'd0; start = 1'b1;
    step();
    n_cmp++;
    if (led !== 16'h0001) begin
      n_fail++;
      $display("FAIL pp_first: led=%h want 0001", led);
    end
    for (int i = 1; i < 16; i++) begin
      step();
      exp = 16'h0001 << i;
      n_cmp++;
      if ({led, done} !== {exp, 1'b0}) begin
        n_fail++;
        $display("FAIL pp_up%0d: led=%h done=%b want led=%h done=0", i, led, done, exp);
      end
    end
    step();
    n_cmp++;
    if ({led, done} !== {16'h4000, 1'b1}) begin
      n_fail++;
      $display("FAIL pp_top: led=%h done=%b want led=4000 done=1", led, done);
    end
    for (int i = 13; i >= 0; i--) begin
      step();
      exp = 16'h0001 << i;
      n_cmp++;
      if ({led, done} !== {exp, 1'b0}) begin
        n_fail++;
        $display("FAIL pp_down%0d: led=%h done=%b want led=%h done=0", i, led, done, exp);
      end
    end
    step();
    n_cmp++;
    if ({led, done} !== {16'h0002, 1'b1}) begin
      n_fail++;
      $display("FAIL pp_bottom: led=%h done=%b want led=0002 done=1", led, done);
    end
    step();
    n_cmp++;
    if ({led, done} !== {16'h0004, 1'b0}) begin
      n_fail++;
      $display("FAIL pp_after: led=%h done=%b want led=0004 done=0", led, done);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_prescale();
    mode = 2'b01; step_div = 4'd3; start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (led !== 16'h0001) begin
        n_fail++;
        $display("FAIL pre_hold1_%0d: led=%h want 0001", i, led);
      end
      step();
    end
    n_cmp++;
    if (led !== 16'h0001) begin
      n_fail++;
      $display("FAIL pre_hold1_3: led=%h want 0001", led);
    end
    step();
    n_cmp++;
    if (led !== 16'h0002) begin
      n_fail++;
      $display("FAIL pre_adv1: led=%h want 0002", led);
    end
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({led, busy, done} !== {16'h0002, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL pre_frozen%0d: led=%h busy=%b done=%b want led=0002 busy=1 done=0", i, led, busy, done);
      end
    end
    en = 1'b1;
    step(); step();
    n_cmp++;
    if (led !== 16'h0002) begin
      n_fail++;
      $display("FAIL pre_hold9: led=%h want 0002", led);
    end
    step();
    n_cmp++;
    if (led !== 16'h0004) begin
      n_fail++;
      $display("FAIL pre_adv2: led=%h want 0004", led);
    end
    step(); step();
    step_div = 4'd1;
    step();
    n_cmp++;
    if (led !== 16'h0008) begin
      n_fail++;
      $display("FAIL pre_lowered: led=%h want 0008", led);
    end
    step_div = 4'd0; start = 1'b0;
    step();
  endtask

  task automatic test_pause();
    mode = 2'b01; step_div = 4'd0; start = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if ({led, pos} !== {16'h0020, 4'd5}) begin
      n_fail++;
      $display("FAIL pause_pre: led=%h pos=%0d want led=0020 pos=5", led, pos);
    end
    idle = 1'b1;
    step();
    n_cmp++;
    if ({led, busy, pos} !== {16'h0000, 1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL pause_enter: led=%h busy=%b pos=%0d want led=0000 busy=1 pos=5", led, busy, pos);
    end
    step();
    n_cmp++;
    if ({led, pos} !== {16'h0000, 4'd5}) begin
      n_fail++;
      $display("FAIL pause_hold: led=%h pos=%0d want led=0000 pos=5", led, pos);
    end
    step_div = 4'd1; idle = 1'b0;
    step();
    n_cmp++;
    if ({led, pos} !== {16'h0020, 4'd5}) begin
      n_fail++;
      $display("FAIL pause_resume: led=%h pos=%0d want led=0020 pos=5", led, pos);
    end
    step();
    n_cmp++;
    if (led !== 16'h0020) begin
      n_fail++;
      $display("FAIL pause_resume_hold: led=%h want 0020", led);
    end
    step();
    n_cmp++;
    if (led !== 16'h0040) begin
      n_fail++;
      $display("FAIL pause_resume_adv: led=%h want 0040", led);
    end
    idle = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if ({led, busy, pos} !== {16'h0000, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL pause_stop: led=%h busy=%b pos=%0d want led=0000 busy=0 pos=0", led, busy, pos);
    end
    idle = 1'b0; step_div = 4'd0;
    step();
  endtask

  task automatic test_mode_switch_reset();
    mode = 2'b01; step_div = 4'd0; start = 1'b1;
    step();
    mode = 2'b11;
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (led !== 16'h8000) begin
      n_fail++;
      $display("FAIL switch_top: led=%h want 8000", led);
    end
    step();
    n_cmp++;
    if ({led, done} !== {16'h0001, 1'b1}) begin
      n_fail++;
      $display("FAIL switch_wrap: led=%h done=%b want led=0001 done=1", led, done);
    end
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({led, pos, busy, done} !== {16'h0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset: led=%h pos=%0d busy=%b done=%b want all zero", led, pos, busy, done);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({led, pos, busy} !== {16'h0001, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart: led=%h pos=%0d busy=%b want led=0001 pos=0 busy=1", led, pos, busy);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_n10_down();
    reset = 1'b1;
    step();
    reset = 1'b0; mode = 2'b10; step_div = 4'd0; start = 1'b1;
    step();
    n_cmp++;
    if ({led10, pos10} !== {10'h200, 4'd9}) begin
      n_fail++;
      $display("FAIL n10_first: led=%h pos=%0d want led=200 pos=9", led10, pos10);
    end
    for (int i = 8; i >= 0; i--) begin
      step();
      exp10 = 10'h001 << i;
      n_cmp++;
      if ({led10, done10} !== {exp10, 1'b0}) begin
        n_fail++;
        $display("FAIL n10_step%0d: led=%h done=%b want led=%h done=0", i, led10, done10, exp10);
      end
    end
    step();
    n_cmp++;
    if ({led10, pos10, done10} !== {10'h200, 4'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL n10_wrap: led=%h pos=%0d done=%b want led=200 pos=9 done=1", led10, pos10, done10);
    end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_mode_none();
    test_sweep_up();
    test_sweep_down();
    test_ping_pong();
    test_prescale();
    test_pause();
    test_mode_switch_reset();
    test_n10_down();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
